// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq_pkg
// Brief    : Shared defaults, reset PC and per-cycle action encoding for the
//            program-counter sequencer.
// Config   : PC_SEQ_STACK_EN (consumed by pc_sequencer, not by this package)
// Revision : 1.0 - initial release
// ============================================================================
package pc_seq_pkg;

  // Default program-memory address width (1024 words).
  localparam int unsigned PC_AW_DEFAULT    = 10;
  // Default number of return-stack entries.
  localparam int unsigned PC_DEPTH_DEFAULT = 8;
  // Value the PC takes on reset and on synchronous restart.
  localparam int unsigned PC_RESET         = 0;

  // Exactly one of these actions is taken on every rising edge.
  typedef enum logic [2:0] {
    ACT_NONE = 3'd0,  // hold (stall)
    ACT_INC  = 3'd1,  // sequential fetch
    ACT_JMP  = 3'd2,  // load target
    ACT_CALL = 3'd3,  // push PC+1, load target
    ACT_RET  = 3'd4,  // pop into PC
    ACT_CLR  = 3'd5   // synchronous restart
  } pc_action_e;

  // Resolve the control inputs into a single action using the fixed priority
  // clr > stall > ret > call > jmp > increment. Without a return stack, ret
  // degrades to a plain increment and call to a plain jump.
  function automatic pc_action_e pc_select_action(
    input logic clr,
    input logic stall,
    input logic ret,
    input logic call,
    input logic jmp,
    input logic stack_en
  );
    pc_action_e act;
    act = ACT_INC;
    if (clr)        act = ACT_CLR;
    else if (stall) act = ACT_NONE;
    else if (ret)   act = stack_en ? ACT_RET  : ACT_INC;
    else if (call)  act = stack_en ? ACT_CALL : ACT_JMP;
    else if (jmp)   act = ACT_JMP;
    return act;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_ret_stack.sv
`default_nettype none
// ============================================================================
// Module   : pc_ret_stack
// Brief    : Pointer-based LIFO of return addresses (DEPTH x AW) with push,
//            pop and flush. Only the occupancy pointer is reset; the storage
//            array is left uninitialised. Used when PC_SEQ_STACK_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module pc_ret_stack
  import pc_seq_pkg::*;
#(
  parameter int unsigned AW    = PC_AW_DEFAULT,
  parameter int unsigned DEPTH = PC_DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [AW-1:0] data_i,
  output logic [AW-1:0] top_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [AW-1:0] mem_q [DEPTH];

  logic          w_do_push;
  logic          w_do_pop;
  logic [PW-1:0] w_wr_idx;
  logic [PW-1:0] w_top_idx;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == CW'(DEPTH));
  assign w_do_push = push_i && !full_o  && !flush_i;
  assign w_do_pop  = pop_i  && !empty_o && !flush_i;

  // DEPTH is a power of two, so the low pointer bits index the next free slot
  // and wrap naturally to DEPTH-1 when reading the top of a full stack.
  assign w_wr_idx  = cnt_q[PW-1:0];
  assign w_top_idx = cnt_q[PW-1:0] - PW'(1);
  assign top_o     = mem_q[w_top_idx];

  // Occupancy update: flush wins, otherwise at most one of push/pop.
  always_comb begin
    cnt_d = cnt_q;
    if (flush_i)        cnt_d = '0;
    else if (w_do_push) cnt_d = cnt_q + CW'(1);
    else if (w_do_pop)  cnt_d = cnt_q - CW'(1);
  end

  // Occupancy pointer register; reset empties the stack immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // Return-address storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[w_wr_idx] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Program counter with jump, call/return (LIFO return stack),
//            stall and synchronous restart. Address is the registered PC and
//            addresses program memory combinationally.
// Config   : PC_SEQ_STACK_EN defined   -> return stack, call/ret, ovf/unf.
//            PC_SEQ_STACK_EN undefined -> call acts as jmp, ret as increment,
//                                         stack status outputs are constant.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned AW    = PC_AW_DEFAULT,
  parameter int unsigned DEPTH = PC_DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          stall,
  input  logic          jmp,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] target,
  output logic [AW-1:0] Address,
  output logic          stk_empty,
  output logic          stk_full,
  output logic          ovf,
  output logic          unf
);

`ifdef PC_SEQ_STACK_EN
  localparam bit c_STACK_EN = 1'b1;
`else
  localparam bit c_STACK_EN = 1'b0;
`endif

  // Reject unsupported stack depths at elaboration time.
  if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("pc_sequencer: DEPTH must be a power of two in the range 2..16");
  end

  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_d;
  logic [AW-1:0] w_pc_inc;
  pc_action_e    w_action;
  logic          w_stk_empty;
  logic          w_stk_full;
  logic [AW-1:0] w_stk_top;

  // Sequential successor; wraps from 2^AW-1 to 0 without any flag.
  assign w_pc_inc = pc_q + AW'(1);
  assign w_action = pc_select_action(clr, stall, ret, call, jmp, c_STACK_EN);

`ifdef PC_SEQ_STACK_EN
  logic w_push;
  logic w_pop;
  logic w_flush;
  logic ovf_q;
  logic ovf_d;
  logic unf_q;
  logic unf_d;

  // A call into a full stack still jumps; only the push is dropped.
  assign w_push  = (w_action == ACT_CALL) && !w_stk_full;
  assign w_pop   = (w_action == ACT_RET)  && !w_stk_empty;
  assign w_flush = (w_action == ACT_CLR);

  pc_ret_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (w_flush),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (w_pc_inc),
    .top_o   (w_stk_top),
    .empty_o (w_stk_empty),
    .full_o  (w_stk_full)
  );

  // Sticky overflow/underflow: set on misuse, cleared only by restart.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    case (w_action)
      ACT_CLR: begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      ACT_CALL: if (w_stk_full)  ovf_d = 1'b1;
      ACT_RET:  if (w_stk_empty) unf_d = 1'b1;
      default: ;
    endcase
  end

  // Sticky flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf = ovf_q;
  assign unf = unf_q;
`else
  // No stack: status reads as permanently empty and error-free.
  assign w_stk_empty = 1'b1;
  assign w_stk_full  = 1'b0;
  assign w_stk_top   = '0;
  assign ovf         = 1'b0;
  assign unf         = 1'b0;
`endif

  assign stk_empty = w_stk_empty;
  assign stk_full  = w_stk_full;

  // Next-PC selection driven by the single prioritised action.
  always_comb begin
    pc_d = w_pc_inc;
    unique case (w_action)
      ACT_CLR:  pc_d = AW'(PC_RESET);
      ACT_NONE: pc_d = pc_q;
      ACT_JMP:  pc_d = target;
      ACT_CALL: pc_d = target;
      ACT_RET:  pc_d = w_stk_empty ? w_pc_inc : w_stk_top;
      ACT_INC:  pc_d = w_pc_inc;
      default:  pc_d = w_pc_inc;
    endcase
  end

  // Program counter register; reset forces the restart address at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc_q <= AW'(PC_RESET);
    else          pc_q <= pc_d;
  end

  assign Address = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Scoreboard bench for pc_sequencer. Directed stimulus pushes the
//            hand-computed post-edge state; a monitor pops and compares after
//            every rising edge. Expectations follow PC_SEQ_STACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

`ifdef PC_SEQ_STACK_EN
  localparam bit c_STACK_EN = 1'b1;
`else
  localparam bit c_STACK_EN = 1'b0;
`endif
  localparam int AW = 10;

  typedef struct {
    logic [AW-1:0] addr;
    logic          empty;
    logic          full;
    logic          ovf;
    logic          unf;
    string         name;
  } exp_t;

  logic          clk;
  logic          reset_n;
  logic          clr;
  logic          stall;
  logic          jmp;
  logic          call;
  logic          ret;
  logic [AW-1:0] target;
  logic [AW-1:0] Address;
  logic          stk_empty;
  logic          stk_full;
  logic          ovf;
  logic          unf;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  pc_sequencer #(
    .AW    (AW),
    .DEPTH (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (clr),
    .stall     (stall),
    .jmp       (jmp),
    .call      (call),
    .ret       (ret),
    .target    (target),
    .Address   (Address),
    .stk_empty (stk_empty),
    .stk_full  (stk_full),
    .ovf       (ovf),
    .unf       (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected state per rising edge, sampled 1 unit later.
  always begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if ({Address, stk_empty, stk_full, ovf, unf} !== {e.addr, e.empty, e.full, e.ovf, e.unf}) begin
        n_fail++;
        $display("FAIL %s: got Address=%0d empty=%b full=%b ovf=%b unf=%b, expected Address=%0d empty=%b full=%b ovf=%b unf=%b",
                 e.name, Address, stk_empty, stk_full, ovf, unf, e.addr, e.empty, e.full, e.ovf, e.unf);
      end
    end
  end

  // Drive one cycle of controls at the falling edge and queue the state
  // expected after the following rising edge.
  task automatic step(input logic c_clr, input logic c_stall, input logic c_ret,
                      input logic c_call, input logic c_jmp, input logic [AW-1:0] tgt,
                      input logic [AW-1:0] a_en, input logic [AW-1:0] a_dis,
                      input logic x_empty, input logic x_full, input logic x_ovf,
                      input logic x_unf, input string nm);
    exp_t e;
    @(negedge clk);
    clr    = c_clr;
    stall  = c_stall;
    ret    = c_ret;
    call   = c_call;
    jmp    = c_jmp;
    target = tgt;
    e.addr  = c_STACK_EN ? a_en    : a_dis;
    e.empty = c_STACK_EN ? x_empty : 1'b1;
    e.full  = c_STACK_EN ? x_full  : 1'b0;
    e.ovf   = c_STACK_EN ? x_ovf   : 1'b0;
    e.unf   = c_STACK_EN ? x_unf   : 1'b0;
    e.name  = nm;
    exp_q.push_back(e);
  endtask

  // Immediate check of the reset state, independent of the clock.
  task automatic check_reset_state(input string nm);
    n_tests++;
    if ({Address, stk_empty, stk_full, ovf, unf} !== {10'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL %s: got Address=%0d empty=%b full=%b ovf=%b unf=%b, expected Address=0 empty=1 full=0 ovf=0 unf=0",
               nm, Address, stk_empty, stk_full, ovf, unf);
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    reset_n = 1'b0;
    clr = 1'b0; stall = 1'b0; jmp = 1'b0; call = 1'b0; ret = 1'b0;
    target = '0;

    // Reset asserted before any clock edge.
    #2;
    check_reset_state("reset_async");
    repeat (3) @(posedge clk);
    #4;
    reset_n = 1'b1;
    check_reset_state("reset_release");

    // Idle fetch after reset release.
    for (int i = 1; i <= 5; i++)
      step(0,0,0,0,0, 10'd0, 10'(i), 10'(i), 1,0,0,0, "idle_inc");

    // Wrap from the top of the address space.
    step(0,0,0,0,1, 10'd1023, 10'd1023, 10'd1023, 1,0,0,0, "jmp_1023");
    step(0,0,0,0,0, 10'd0,    10'd0,    10'd0,    1,0,0,0, "wrap_to_0");

    // Call/return round trip, with a stall holding the call.
    step(0,0,0,0,1, 10'd10,  10'd10,  10'd10,  1,0,0,0, "jmp_10");
    step(0,0,0,1,0, 10'd200, 10'd200, 10'd200, 0,0,0,0, "call_200");
    step(0,1,0,1,0, 10'd300, 10'd200, 10'd200, 0,0,0,0, "stall_call");
    step(0,0,1,0,0, 10'd0,   10'd11,  10'd201, 1,0,0,0, "ret_to_11");

    // call and ret together: ret has priority.
    step(0,0,0,0,1, 10'd20, 10'd20, 10'd20, 1,0,0,0, "jmp_20");
    step(0,0,0,1,0, 10'd40, 10'd40, 10'd40, 0,0,0,0, "call_40");
    step(0,0,1,1,0, 10'd99, 10'd21, 10'd41, 1,0,0,0, "call_ret_same");

    // Nested calls to overflow, then full unwind.
    step(0,0,0,0,1, 10'd100, 10'd100, 10'd100, 1,0,0,0, "jmp_100");
    for (int k = 1; k <= 9; k++)
      step(0,0,0,1,0, 10'(600 + 10*k), 10'(600 + 10*k), 10'(600 + 10*k),
           0, (k >= 8), (k == 9), 0, "nest_call");
    for (int j = 1; j <= 8; j++)
      step(0,0,1,0,0, 10'd0, (j < 8) ? 10'(681 - 10*j) : 10'd101, 10'(690 + j),
           (j == 8), 0, 1, 0, "nest_ret");

    // Underflow on empty return, then restart clears flags.
    step(0,0,0,0,1, 10'd50, 10'd50, 10'd50, 1,0,1,0, "jmp_50");
    step(0,0,1,0,0, 10'd0,  10'd51, 10'd51, 1,0,1,1, "ret_empty");
    step(1,0,0,0,0, 10'd0,  10'd0,  10'd0,  1,0,0,0, "clr");
    step(0,0,0,0,0, 10'd0,  10'd1,  10'd1,  1,0,0,0, "after_clr");
    step(0,0,1,0,0, 10'd0,  10'd2,  10'd2,  1,0,0,1, "ret_empty2");
    step(0,0,0,0,0, 10'd0,  10'd3,  10'd3,  1,0,0,1, "unf_sticky");
    step(1,1,0,1,0, 10'd5,  10'd0,  10'd0,  1,0,0,0, "clr_beats_stall");

    // Restart flushes a non-empty stack.
    step(0,0,0,1,0, 10'd300, 10'd300, 10'd300, 0,0,0,0, "call_300");
    step(1,0,0,0,0, 10'd0,   10'd0,   10'd0,   1,0,0,0, "clr_flush");
    step(0,0,1,0,0, 10'd0,   10'd1,   10'd1,   1,0,0,1, "ret_after_flush");
    step(1,0,0,0,0, 10'd0,   10'd0,   10'd0,   1,0,0,0, "clr2");

    // Asynchronous reset pulse while stalled with a pending call.
    step(0,0,0,1,0, 10'd77, 10'd77, 10'd77, 0,0,0,0, "call_77");
    step(0,1,0,0,1, 10'd9,  10'd77, 10'd77, 0,0,0,0, "stall_jmp");
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_state("reset_mid_stall");
    reset_n = 1'b1;
    step(0,0,0,0,0, 10'd0, 10'd1, 10'd1, 1,0,0,0, "after_reset_pulse");

    // Drain the scoreboard with a bounded wait.
    @(negedge clk);
    clr = 1'b0; stall = 1'b1; jmp = 1'b0; call = 1'b0; ret = 1'b0;
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expected entries never compared, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
